dmem_arbiter: RTL

// Shares the single-port 256x16 synchronous data memory between the PCPU data port and an external

---
 rtl/dmem_arbiter.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port 256x16 synchronous data memory between the PCPU
//   data port and an external host (loader/debug) port. The CPU owns the
//   memory by default. A host burst freezes the pipeline through cpu_enable,
//   runs a bounded read or write burst, and then hands the memory back.
//   After every host grant the CPU keeps the memory for at least CPU_SLOT
//   cycles, so it still makes progress between long host bursts.
//
// Parameters
//   MAX_BURST  max host words per grant (1..256); longer bursts are split
//   CPU_SLOT   min CPU-owned cycles after each host grant (>=1)
//
// Ports
//   clock           system clock, rising edge
//   reset           asynchronous, active-low reset
//   cpu_enable_req  board-level run enable for the PCPU
//   cpu_enable      PCPU enable = cpu_enable_req & reset & CPU owns memory
//   cpu_d_addr      PCPU data address
//   cpu_d_dataout   PCPU store data
//   cpu_d_we        PCPU store strobe
//   cpu_d_datain    load data returned to the PCPU (held while frozen)
//   host_req        level request, held until host_done or abandoned
//   host_we         1 = write burst, 0 = read burst
//   host_addr       burst base address
//   host_len        burst length minus 1
//   host_wdata      write word, consumed in every cycle host_wack=1
//   host_grant      high in DRAIN/HOST/TAIL
//   host_wack       write word consumed this cycle
//   host_rdata      read word
//   host_rvalid     host_rdata valid this cycle
//   host_done       one-cycle pulse when the whole burst has completed
//   mem_addr        memory address
//   mem_wdata       memory write data
//   mem_we          memory write enable
//   mem_rdata       memory read data, valid one cycle after the address
module dmem_arbiter #(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned CPU_SLOT  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_enable_req,
    output logic        cpu_enable,
    input  logic [7:0]  cpu_d_addr,
    input  logic [15:0] cpu_d_dataout,
    input  logic        cpu_d_we,
    output logic [15:0] cpu_d_datain,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [7:0]  host_addr,
    input  logic [7:0]  host_len,
    input  logic [15:0] host_wdata,
    output logic        host_grant,
    output logic        host_wack,
    output logic [15:0] host_rdata,
    output logic        host_rvalid,
    output logic        host_done,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata
);

    localparam int unsigned    CW         = $clog2(CPU_SLOT + 1);
    localparam logic [7:0]     GRANT_LAST = 8'(MAX_BURST - 1);
    localparam logic [CW-1:0]  COOL_INIT  = CW'(CPU_SLOT);
    localparam logic [CW-1:0]  COOL_ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_HOST,
        S_TAIL,
        S_COOL
    } state_e;

    state_e         state_q, state_d;
    logic [7:0]     base_q, base_d;
    logic [7:0]     len_q, len_d;
    logic           we_q, we_d;
    logic [7:0]     done_cnt_q, done_cnt_d;
    logic [7:0]     grant_cnt_q, grant_cnt_d;
    logic [CW-1:0]  cool_q, cool_d;
    logic           busy_q, busy_d;
    logic           fin_q, fin_d;       // burst finished in this grant -> host_done in TAIL
    logic           rvalid_q;
    logic           prev_cpu_q;         // previous cycle was a CPU-owned access
    logic [15:0]    held_q;             // last load value seen by the CPU
    logic [7:0]     cpu_addr_q;         // last CPU address, re-presented in DRAIN

    logic           cpu_own;
    logic           host_go;            // live host access this cycle

    assign cpu_own = (state_q == S_IDLE) || (state_q == S_COOL);
    // A dropped request in HOST performs no access; the cycle only exits.
    assign host_go = (state_q == S_HOST) && host_req;

    // ------------------------------------------------------------------
    // State and burst bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            we_q        <= 1'b0;
            done_cnt_q  <= '0;
            grant_cnt_q <= '0;
            cool_q      <= '0;
            busy_q      <= 1'b0;
            fin_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            we_q        <= we_d;
            done_cnt_q  <= done_cnt_d;
            grant_cnt_q <= grant_cnt_d;
            cool_q      <= cool_d;
            busy_q      <= busy_d;
            fin_q       <= fin_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        we_d        = we_q;
        done_cnt_d  = done_cnt_q;
        grant_cnt_d = grant_cnt_q;
        cool_d      = cool_q;
        busy_d      = busy_q;
        fin_d       = fin_q;

        unique case (state_q)
            S_IDLE: begin
                if (host_req) begin
                    state_d = S_DRAIN;
                    // A truncated burst keeps its descriptor and resumes.
                    if (!busy_q) begin
                        base_d     = host_addr;
                        len_d      = host_len;
                        we_d       = host_we;
                        done_cnt_d = '0;
                    end
                end
            end
            S_DRAIN: begin
                state_d     = S_HOST;
                busy_d      = 1'b1;
                grant_cnt_d = '0;
                fin_d       = 1'b0;
            end
            S_HOST: begin
                if (!host_req) begin
                    state_d = S_TAIL;
                    busy_d  = 1'b0;
                    fin_d   = 1'b0;
                end else begin
                    done_cnt_d  = done_cnt_q + 8'd1;
                    grant_cnt_d = grant_cnt_q + 8'd1;
                    // Counters hold the index of the word issued this cycle,
                    // so exits compare the pre-increment values.
                    if (done_cnt_q == len_q) begin
                        state_d = S_TAIL;
                        busy_d  = 1'b0;
                        fin_d   = 1'b1;
                    end else if (grant_cnt_q == GRANT_LAST) begin
                        state_d = S_TAIL;
                        fin_d   = 1'b0;
                    end
                end
            end
            S_TAIL: begin
                state_d = S_COOL;
                cool_d  = COOL_INIT;
            end
            S_COOL: begin
                cool_d = cool_q - COOL_ONE;
                if (cool_q == COOL_ONE) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read-data return paths
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rvalid_q   <= 1'b0;
            prev_cpu_q <= 1'b0;
            held_q     <= '0;
            cpu_addr_q <= '0;
        end else begin
            rvalid_q   <= host_go && !we_q;
            prev_cpu_q <= cpu_own;
            held_q     <= cpu_d_datain;
            if (cpu_own) begin
                cpu_addr_q <= cpu_d_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        cpu_enable   = cpu_enable_req && reset && cpu_own;
        host_grant   = (state_q == S_DRAIN) || (state_q == S_HOST) || (state_q == S_TAIL);
        host_wack    = host_go && we_q;
        host_rvalid  = rvalid_q;
        host_rdata   = mem_rdata;
        host_done    = (state_q == S_TAIL) && fin_q;
        // Freshly returned data only when the CPU issued the access; otherwise
        // the frozen pipeline keeps seeing its last load.
        cpu_d_datain = prev_cpu_q ? mem_rdata : held_q;

        mem_addr  = cpu_addr_q;
        mem_wdata = host_wdata;
        mem_we    = 1'b0;
        if (cpu_own) begin
            mem_addr  = cpu_d_addr;
            mem_wdata = cpu_d_dataout;
            mem_we    = cpu_d_we && reset;
        end else if (state_q == S_HOST) begin
            mem_addr = base_q + done_cnt_q;
            mem_we   = host_go && we_q && reset;
        end
    end

endmodule
